// File: rtl/fpu_issue_ctrl.sv
// FPU issue/sequencing controller: accepts one op at a time, classifies it and
// steps the datapath through single-pass, two-pass or iterative execution.
module fpu_issue_ctrl #(
  parameter int DIV_CYCLES  = 24,
  parameter int SQRT_CYCLES = 24,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       req_valid,
  input  logic [4:0] req_op,
  output logic       req_ready,
  output logic [4:0] cur_op,
  output logic       in_sel,
  output logic       reg_AB_en,
  output logic       iter_en,
  output logic       iter_first,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS2 = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0]       OP_DIV    = 5'b00110;
  localparam logic [4:0]       OP_SQRT   = 5'b00111;
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_CYCLES - 1);

  function automatic logic is_two_pass(input logic [4:0] op);
    return (op == 5'b00010) || (op == 5'b00011) || (op == 5'b01011);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cur_op_q, cur_op_d;
  logic             accept_s;
  logic [CNT_W-1:0] first_load_s;

  // Handshake: flush and reset both block acceptance in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    accept_s  = 1'b0;
    if (!reset && !flush && (state_q == S_IDLE)) begin
      req_ready = 1'b1;
      accept_s  = req_valid;
    end else begin
      req_ready = 1'b0;
      accept_s  = 1'b0;
    end
  end

  // Next-state, counter and opcode latch; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_op_d = cur_op_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            cur_op_d = req_op;
            if (is_two_pass(req_op)) begin
              state_d = S_PASS2;
            end else if (req_op == OP_DIV) begin
              state_d = S_ITER;
              cnt_d   = DIV_LOAD;
            end else if (req_op == OP_SQRT) begin
              state_d = S_ITER;
              cnt_d   = SQRT_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PASS2: begin
          state_d = S_DONE;
        end
        S_ITER: begin
          // Decrement only while nonzero so the counter can never wrap.
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and opcode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cur_op_q <= 5'b00000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_op_q <= cur_op_d;
    end
  end

  // The first ITER cycle is the one where the counter still holds its load value.
  always_comb begin
    if (cur_op_q == OP_SQRT) begin
      first_load_s = SQRT_LOAD;
    end else begin
      first_load_s = DIV_LOAD;
    end
  end

  // Datapath controls; everything is forced low while reset is asserted.
  always_comb begin
    in_sel     = 1'b0;
    reg_AB_en  = 1'b0;
    iter_en    = 1'b0;
    iter_first = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    cur_op     = 5'b00000;
    if (!reset) begin
      cur_op = cur_op_q;
      busy   = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          in_sel    = 1'b1;
          reg_AB_en = accept_s;
        end
        S_PASS2: begin
          reg_AB_en = 1'b1;
        end
        S_ITER: begin
          iter_en    = 1'b1;
          iter_first = (cnt_q == first_load_s);
        end
        S_DONE: begin
          // A flushed result must not be seen as consumable.
          res_valid = !flush;
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end else begin
      cur_op = 5'b00000;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl (DIV_CYCLES=4, SQRT_CYCLES=1).
module tb_fpu_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       req_valid;
  logic [4:0] req_op;
  logic       req_ready;
  logic [4:0] cur_op;
  logic       in_sel;
  logic       reg_AB_en;
  logic       iter_en;
  logic       iter_first;
  logic       res_valid;
  logic       res_ready;
  logic       busy;

  int errors;
  int checks;

  fpu_issue_ctrl #(.DIV_CYCLES(4), .SQRT_CYCLES(1), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .cur_op(cur_op), .in_sel(in_sel), .reg_AB_en(reg_AB_en),
    .iter_en(iter_en), .iter_first(iter_first),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge and outputs are sampled 1 time unit later.
  task automatic test_reset();
    logic [11:0] outs;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b1; req_op = 5'b01011; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    outs = {req_ready, in_sel, reg_AB_en, iter_en, iter_first, res_valid, busy, cur_op};
    checks++; if (outs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h expected 000", outs); end
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy); end
  endtask

  task automatic test_single();
    @(negedge clk); req_valid = 1'b1; req_op = 5'b00000; res_ready = 1'b1; #1;
    checks++; if (reg_AB_en !== 1'b1 || in_sel !== 1'b1) begin errors++; $display("FAIL single_T: got en=%b sel=%b expected 1 1", reg_AB_en, in_sel); end
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL single_T1: got rv=%b busy=%b rdy=%b expected 1 1 0", res_valid, busy, req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL single_T2: got rdy=%b rv=%b expected 1 0", req_ready, res_valid); end
  endtask

  task automatic test_two_pass();
    @(negedge clk); req_valid = 1'b1; req_op = 5'b01011; res_ready = 1'b0; #1;
    checks++; if (in_sel !== 1'b1 || reg_AB_en !== 1'b1) begin errors++; $display("FAIL two_pass_T: got sel=%b en=%b expected 1 1", in_sel, reg_AB_en); end
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (in_sel !== 1'b0 || reg_AB_en !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL two_pass_T1: got sel=%b en=%b rv=%b expected 0 1 0", in_sel, reg_AB_en, res_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (res_valid !== 1'b1 || cur_op !== 5'b01011) begin errors++; $display("FAIL two_pass_hold%0d: got rv=%b op=%b expected 1 01011", i, res_valid, cur_op); end
    end
    @(negedge clk); res_ready = 1'b1; #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL two_pass_consume: got rv=%b expected 1", res_valid); end
    @(negedge clk); res_ready = 1'b0; #1;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL two_pass_idle: got rv=%b rdy=%b expected 0 1", res_valid, req_ready); end
  endtask

  task automatic test_iter_div();
    @(negedge clk); req_valid = 1'b1; req_op = 5'b00110; res_ready = 1'b1; #1;
    checks++; if (iter_en !== 1'b0 || reg_AB_en !== 1'b1) begin errors++; $display("FAIL div_T: got it=%b en=%b expected 0 1", iter_en, reg_AB_en); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); req_valid = 1'b0; #1;
      checks++;
      if (iter_en !== 1'b1 || iter_first !== (k == 1) || res_valid !== 1'b0 || in_sel !== 1'b0 || reg_AB_en !== 1'b0) begin
        errors++; $display("FAIL div_iter%0d: got it=%b first=%b rv=%b sel=%b en=%b expected 1 %0d 0 0 0", k, iter_en, iter_first, res_valid, in_sel, reg_AB_en, (k == 1));
      end
    end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b1 || iter_en !== 1'b0) begin errors++; $display("FAIL div_T5: got rv=%b it=%b expected 1 0", res_valid, iter_en); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL div_T6: got rdy=%b expected 1", req_ready); end
  endtask

  task automatic test_iter_sqrt();
    @(negedge clk); req_valid = 1'b1; req_op = 5'b00111; res_ready = 1'b1; #1;
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (iter_en !== 1'b1 || iter_first !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL sqrt_T1: got it=%b first=%b rv=%b expected 1 1 0", iter_en, iter_first, res_valid); end
    @(negedge clk); #1;
    checks++; if (iter_en !== 1'b0 || res_valid !== 1'b1) begin errors++; $display("FAIL sqrt_T2: got it=%b rv=%b expected 0 1", iter_en, res_valid); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sqrt_T3: got rdy=%b busy=%b expected 1 0", req_ready, busy); end
  endtask

  task automatic test_flush();
    int rv_seen;
    @(negedge clk); req_valid = 1'b1; req_op = 5'b00110; res_ready = 1'b0; #1;
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (iter_en !== 1'b1) begin errors++; $display("FAIL flush_pre: got it=%b expected 1", iter_en); end
    @(negedge clk); flush = 1'b1; #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got rdy=%b expected 0", req_ready); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (req_ready !== 1'b1 || iter_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got rdy=%b it=%b busy=%b expected 1 0 0", req_ready, iter_en, busy); end
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (res_valid === 1'b1) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL flush_no_result: got %0d res_valid cycles expected 0", rv_seen); end
    @(negedge clk); flush = 1'b1; req_valid = 1'b1; req_op = 5'b00010; #1;
    checks++; if (req_ready !== 1'b0 || reg_AB_en !== 1'b0) begin errors++; $display("FAIL flush_req_ready: got rdy=%b en=%b expected 0 0", req_ready, reg_AB_en); end
    @(negedge clk); flush = 1'b0; req_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0 || cur_op !== 5'b00110) begin errors++; $display("FAIL flush_no_accept: got busy=%b op=%b expected 0 00110", busy, cur_op); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [3];
    logic [7:0] acc_mask;
    logic [7:0] res_mask;
    int idx;
    int overlap;
    ops[0] = 5'b00000; ops[1] = 5'b00010; ops[2] = 5'b00000;
    acc_mask = 8'h00; res_mask = 8'h00; idx = 0; overlap = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (idx < 3) begin
        req_valid = 1'b1; req_op = ops[idx];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (req_valid && req_ready) begin
        acc_mask[c] = 1'b1; idx++;
      end
      if (res_valid) res_mask[c] = 1'b1;
      if (busy && req_ready) overlap++;
    end
    req_valid = 1'b0; res_ready = 1'b0;
    checks++; if (acc_mask !== 8'b0010_0101) begin errors++; $display("FAIL b2b_accepts: got %b expected 00100101", acc_mask); end
    checks++; if (res_mask !== 8'b0101_0010) begin errors++; $display("FAIL b2b_results: got %b expected 01010010", res_mask); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d overlap cycles expected 0", overlap); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] outs;
    int rv_seen;
    @(negedge clk); req_valid = 1'b1; req_op = 5'b00011; res_ready = 1'b1; #1;
    @(negedge clk); req_valid = 1'b0; reset = 1'b1; #1;
    outs = {req_ready, in_sel, reg_AB_en, iter_en, iter_first, res_valid, busy, cur_op};
    checks++; if (outs !== 12'h000) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 000", outs); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || cur_op !== 5'b00000) begin errors++; $display("FAIL rst_mid_idle: got busy=%b rdy=%b op=%b expected 0 1 00000", busy, req_ready, cur_op); end
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (res_valid === 1'b1) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d res_valid cycles expected 0", rv_seen); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 5'b00000; res_ready = 1'b0;
    test_reset();
    test_single();
    test_two_pass();
    test_iter_div();
    test_iter_sqrt();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue and sequencing controller for the FPU arithmetic datapath. It accepts one floating-point operation at a time from the core's execute stage over a valid/ready handshake, classifies the 5-bit FPU opcode by execution class, and drives the datapath's operand-select, operand-register-enable and iteration controls for the required number of cycles. It then presents a held result-valid until the core consumes it, and supports a pipeline flush at any point.

## Interface
Parameters:
- DIV_CYCLES, 24, iteration cycles for divide (op 5'b00110); legal range 1..2^CNT_W
- SQRT_CYCLES, 24, iteration cycles for square root (op 5'b00111); legal range 1..2^CNT_W
- CNT_W, 5, width of the iteration down-counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort the current operation and drop any pending result
- req_valid  in  1  core presents an FPU op
- req_op  in  5  FPU opcode, sampled on accept
- req_ready  out  1  controller can accept; high only in IDLE with flush low
- cur_op  out  5  latched opcode driven to the datapath
- in_sel  out  1  1 = datapath takes external operands, 0 = feedback/second-pass operands
- reg_AB_en  out  1  operand register load enable
- iter_en  out  1  iterative unit step enable
- iter_first  out  1  first iteration cycle marker
- res_valid  out  1  result available on the datapath output
- res_ready  in  1  core consumes the result
- busy  out  1  high in any state other than IDLE

## Operation
- Accept occurs when req_valid && req_ready. req_op is latched into cur_op on accept. cur_op holds its value until the next accept.
- Opcode classes:
  - TWO_PASS: 5'b00010, 5'b00011, 5'b01011.
  - ITER: 5'b00110 (N = DIV_CYCLES) and 5'b00111 (N = SQRT_CYCLES).
  - SINGLE: all other opcodes.
- States are IDLE, PASS2, ITER and DONE.
- IDLE:
  - in_sel = 1 and reg_AB_en = req_valid && req_ready.
  - SINGLE accept goes to DONE. TWO_PASS accept goes to PASS2. ITER accept loads counter = N-1 and goes to ITER.
  - Without an accept, the state stays IDLE.
- PASS2:
  - in_sel = 0 and reg_AB_en = 1, which loads the second-pass operands.
  - Always goes to DONE after one cycle.
- ITER:
  - iter_en = 1, in_sel = 0, reg_AB_en = 0.
  - iter_first = 1 only in the first ITER cycle.
  - The counter decrements each cycle. When counter == 0, the state goes to DONE.
- DONE:
  - res_valid = 1, and all other controls are 0.
  - res_valid holds until res_ready is high, then the state goes to IDLE.
  - res_valid must not drop without res_ready (or flush/reset).
- flush has priority over every transition:
  - The next state is IDLE, the counter is cleared and any result is discarded.
  - req_ready is 0 during a flush cycle, so no accept can coincide with a flush.
- Control outputs are combinational from state, counter and inputs. State, counter and cur_op are registered.
- Counter arithmetic is unsigned CNT_W bits and never wraps: the decrement is performed only when the counter is nonzero.
- Reset:
  - state = IDLE, counter = 0, cur_op = 5'b00000.
  - While reset is asserted, every output is 0, including req_ready.
  - After reset deasserts, req_ready = 1 in IDLE.
  - Reset mid-operation abandons the operation exactly like a flush.

## Timing
- Latency from the accept cycle T to the first res_valid cycle:
  - SINGLE: T+1.
  - TWO_PASS: T+2.
  - ITER: T+1+N, with iter_en high for exactly N cycles, T+1..T+N.
- Throughput is one op per (latency + 1) cycles at minimum. The earliest next accept is the cycle after res_valid && res_ready.
- res_ready asserted before res_valid is ignored. There is no result skid; the controller stalls in DONE indefinitely.
- busy = 1 from T+1 through the cycle in which the result is consumed.

## Test plan
- Reset then SINGLE: reset high 2 cycles, check all outputs are 0. Then req_op=5'b00000 accepted at T with res_ready=1 held:
  - at T: reg_AB_en=1, in_sel=1.
  - at T+1: res_valid=1 and busy=1.
  - at T+2: req_ready=1.
- TWO_PASS with op 5'b01011:
  - at T: in_sel=1, reg_AB_en=1.
  - at T+1: PASS2 with in_sel=0, reg_AB_en=1.
  - at T+2: res_valid=1.
  - With res_ready held low for 5 cycles, res_valid stays 1 for all 5 and cur_op stays 5'b01011.
- ITER divide with DIV_CYCLES=4:
  - iter_en=1 at T+1..T+4, iter_first=1 only at T+1.
  - res_valid at T+5.
  - Repeat with SQRT_CYCLES=1: iter_en only at T+1, res_valid at T+2.
- Flush during ITER: pulse flush at T+2 of a 24-cycle divide.
  - Next cycle: IDLE, req_ready=1, iter_en=0, and no res_valid ever appears.
  - Flush in the same cycle as req_valid: no accept, and cur_op is unchanged.
- Back-to-back ops: queue SINGLE, TWO_PASS, SINGLE with req_valid held high and res_ready=1.
  - Accepts occur at cycles 0, 2 and 5.
  - res_valid occurs at cycles 1, 4 and 6.
  - req_ready=0 whenever busy=1.
- Synchronous reset at T+1 of a TWO_PASS op: all outputs are 0 during reset, then IDLE with cur_op=5'b00000. No res_valid follows.
